// File: rtl/alu_pipe_hs.sv
// rtl/alu_pipe_hs.sv - two-stage valid/ready signed ALU with two opcode sets
//
// Purpose: accepts one operand beat per cycle into stage 1, computes the
// result at DATA_W+1 bits and registers it (narrowed to OUT_W) in stage 2.
// Latency accept -> out_valid is 2 cycles; back-pressure ripples through
// both stages so full throughput holds while out_ready stays high.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear of both stages
//   en                   input enable (gates in_ready only)
//   in_valid/in_ready    input handshake
//   a_en, b_en           mode: 10 set A, 01 set B1, 11 set B2, 00 idle
//   a_op, b_op           opcode for set A / sets B1,B2
//   A, B                 signed operands
//   out_valid/out_ready  output handshake
//   C, ovf, err          result, overflow flag, idle-beat flag
//   txn_cnt              delivered results, saturating
//
// Optional feature: define ALU_SAT_EN to clamp C on overflow instead of
// wrapping it.
module alu_pipe_hs #(
  parameter int DATA_W = 5,
  parameter int OUT_W  = DATA_W + 1,
  parameter int A_OP_W = 3,
  parameter int B_OP_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a_en,
  input  logic              b_en,
  input  logic [A_OP_W-1:0] a_op,
  input  logic [B_OP_W-1:0] b_op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  C,
  output logic              ovf,
  output logic              err,
  output logic [CNT_W-1:0]  txn_cnt
);

  localparam int W1 = DATA_W + 1;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_B1   = 2'b01,
    MODE_A    = 2'b10,
    MODE_B2   = 2'b11
  } mode_e;

  // Stage 1: raw beat
  logic              s1_valid_q;
  mode_e             s1_mode_q;
  logic [A_OP_W-1:0] s1_a_op_q;
  logic [B_OP_W-1:0] s1_b_op_q;
  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] s1_b_q;

  // Stage 2: finished result
  logic              s2_valid_q;
  logic [OUT_W-1:0]  s2_c_q;
  logic              s2_ovf_q;
  logic              s2_err_q;
  logic [CNT_W-1:0]  txn_q;

  logic s1_adv, s2_adv, accept;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = en && s1_adv && !flush;
  assign accept   = in_valid && in_ready;

  // Arithmetic ops use sign-extended operands, logic ops zero-extended.
  logic [W1-1:0] sa, sb, za, zb, res_w1;
  logic          arith_d, err_d;

  always_comb begin
    sa      = {s1_a_q[DATA_W-1], s1_a_q};
    sb      = {s1_b_q[DATA_W-1], s1_b_q};
    za      = {1'b0, s1_a_q};
    zb      = {1'b0, s1_b_q};
    res_w1  = '0;
    arith_d = 1'b0;
    err_d   = 1'b0;
    // An X opcode matches no item and lands on the zero default.
    case (s1_mode_q)
      MODE_A: begin
        case (s1_a_op_q)
          A_OP_W'(0):             begin res_w1 = sa + sb; arith_d = 1'b1; end
          A_OP_W'(1):             begin res_w1 = sa - sb; arith_d = 1'b1; end
          A_OP_W'(2):             res_w1 = za ^ zb;
          A_OP_W'(3), A_OP_W'(4): res_w1 = za & zb;
          A_OP_W'(5):             res_w1 = za | zb;
          A_OP_W'(6):             res_w1 = ~(za ^ zb);
          default:                res_w1 = '0;
        endcase
      end
      MODE_B1: begin
        case (s1_b_op_q)
          B_OP_W'(0):             res_w1 = ~za | ~zb;
          B_OP_W'(1), B_OP_W'(2): begin res_w1 = sa + sb; arith_d = 1'b1; end
          default:                res_w1 = '0;
        endcase
      end
      MODE_B2: begin
        case (s1_b_op_q)
          B_OP_W'(0): res_w1 = za ^ zb;
          B_OP_W'(1): res_w1 = ~(za ^ zb);
          B_OP_W'(2): begin res_w1 = sa - W1'(1); arith_d = 1'b1; end
          B_OP_W'(3): begin res_w1 = sb + W1'(2); arith_d = 1'b1; end
          default:    res_w1 = '0;
        endcase
      end
      default: err_d = 1'b1;
    endcase
  end

  // The W1 value fits OUT_W iff every bit from the OUT_W sign bit upward
  // agrees; with OUT_W == W1 this slice is one bit, so ovf never fires.
  logic [W1-OUT_W:0] top_bits;
  logic              ovf_d;
  logic [OUT_W-1:0]  c_d;

  assign top_bits = res_w1[W1-1:OUT_W-1];
  assign ovf_d    = arith_d && !((&top_bits) || !(|top_bits));

  always_comb begin
    c_d = res_w1[OUT_W-1:0];
`ifdef ALU_SAT_EN
    if (ovf_d) begin
      c_d = res_w1[W1-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_IDLE;
      s1_a_op_q  <= '0;
      s1_b_op_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_ovf_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      txn_q      <= '0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s1_adv) s1_valid_q <= accept;
        if (s2_adv) s2_valid_q <= s1_valid_q;
      end
      if (accept) begin
        s1_mode_q <= mode_e'({a_en, b_en});
        s1_a_op_q <= a_op;
        s1_b_op_q <= b_op;
        s1_a_q    <= A;
        s1_b_q    <= B;
      end
      // Result regs only move when a real beat advances, so a stalled
      // output stays stable.
      if (s2_adv && s1_valid_q && !flush) begin
        s2_c_q   <= c_d;
        s2_ovf_q <= ovf_d;
        s2_err_q <= err_d;
      end
      if (s2_valid_q && out_ready && !(&txn_q)) begin
        txn_q <= txn_q + CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && accept) begin
      assert (!(({a_en, b_en} == 2'b10) && $isunknown(a_op)))
        else $error("alu_pipe_hs: unknown a_op on accepted beat");
      assert (!(b_en && $isunknown(b_op)))
        else $error("alu_pipe_hs: unknown b_op on accepted beat");
    end
  end
`endif

  assign out_valid = s2_valid_q;
  assign C         = s2_c_q;
  assign ovf       = s2_ovf_q;
  assign err       = s2_err_q;
  assign txn_cnt   = txn_q;

endmodule

// File: tb/tb_alu_pipe_hs.sv
// tb/tb_alu_pipe_hs.sv - bench for alu_pipe_hs at OUT_W=6 and OUT_W=5
module tb_alu_pipe_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, en, in_valid, a_en, b_en, out_ready;
  logic [2:0] a_op;
  logic [1:0] b_op;
  logic [4:0] A, B;
  logic       in_ready6, out_valid6, ovf6, err6;
  logic       in_ready5, out_valid5, ovf5, err5;
  logic [5:0] C6;
  logic [4:0] C5;
  logic [15:0] txn6, txn5;

  alu_pipe_hs #(.DATA_W(5), .OUT_W(6)) u6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .en(en), .in_valid(in_valid),
    .in_ready(in_ready6), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
    .A(A), .B(B), .out_valid(out_valid6), .out_ready(out_ready), .C(C6),
    .ovf(ovf6), .err(err6), .txn_cnt(txn6)
  );

  alu_pipe_hs #(.DATA_W(5), .OUT_W(5)) u5 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .en(en), .in_valid(in_valid),
    .in_ready(in_ready5), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
    .A(A), .B(B), .out_valid(out_valid5), .out_ready(out_ready), .C(C5),
    .ovf(ovf5), .err(err5), .txn_cnt(txn5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int w1; bit arith; bit e; } beat_t;
  beat_t sb_q[$];
  int    exp_txn = 0;
  bit    prev_stall = 0;
  int    prev_c6, prev_c5, prev_o6, prev_e6;

  typedef struct {
    logic [1:0] mode;
    int aop, bop, a, b;
    int c6; bit o6;
    int c5w, c5s; bit o5;
    bit e;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: full-precision value of the beat using plain integers.
  function automatic beat_t ref_beat(input logic [1:0] mode, input int aop, input int bop,
                                     input int a, input int b);
    beat_t r;
    int za, zb;
    za = a & 31;
    zb = b & 31;
    r.w1 = 0; r.arith = 0; r.e = 0;
    case (mode)
      2'b10: case (aop)
        0: begin r.w1 = a + b; r.arith = 1; end
        1: begin r.w1 = a - b; r.arith = 1; end
        2: r.w1 = za ^ zb;
        3, 4: r.w1 = za & zb;
        5: r.w1 = za | zb;
        6: r.w1 = ~(za ^ zb) & 63;
        default: r.w1 = 0;
      endcase
      2'b01: case (bop)
        0: r.w1 = (~za | ~zb) & 63;
        1, 2: begin r.w1 = a + b; r.arith = 1; end
        default: r.w1 = 0;
      endcase
      2'b11: case (bop)
        0: r.w1 = za ^ zb;
        1: r.w1 = ~(za ^ zb) & 63;
        2: begin r.w1 = a - 1; r.arith = 1; end
        3: begin r.w1 = b + 2; r.arith = 1; end
        default: r.w1 = 0;
      endcase
      default: r.e = 1;
    endcase
    return r;
  endfunction

  task automatic narrow(input int v, input bit arith, input int w, output int c, output bit o);
    int lo, hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    o = arith && (v < lo || v > hi);
    c = v;
`ifdef ALU_SAT_EN
    if (o) c = (v < 0) ? lo : hi;
`endif
    c = c & ((1 << w) - 1);
  endtask

  // Runs on the falling edge: queue holds exactly the beats in flight.
  task automatic monitor();
    beat_t bt;
    int c;
    bit o;
    if (!rst_n) begin
      sb_q.delete();
      exp_txn = 0;
      prev_stall = 0;
      return;
    end
    chk("txn_cnt6", txn6, exp_txn);
    chk("txn_cnt5", txn5, exp_txn);
    chk("in_ready6", in_ready6, int'(en && !flush && (sb_q.size() < 2 || out_ready)));
    chk("in_ready5", in_ready5, int'(en && !flush && (sb_q.size() < 2 || out_ready)));
    if (prev_stall) begin
      chk("stall_valid", out_valid6, 1);
      chk("stall_c6", C6, prev_c6);
      chk("stall_c5", C5, prev_c5);
      chk("stall_ovf6", ovf6, prev_o6);
      chk("stall_err6", err6, prev_e6);
    end
    if (out_valid6 && out_ready) begin
      chk("result_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        bt = sb_q.pop_front();
        narrow(bt.w1, bt.arith, 6, c, o);
        chk("c6", C6, c);
        chk("ovf6", ovf6, o);
        chk("err6", err6, bt.e);
        narrow(bt.w1, bt.arith, 5, c, o);
        chk("c5", C5, c);
        chk("ovf5", ovf5, o);
        chk("err5", err5, bt.e);
        if (exp_txn < 65535) exp_txn++;
      end
    end
    if (flush) sb_q.delete();
    else if (in_valid && in_ready6)
      sb_q.push_back(ref_beat({a_en, b_en}, int'(a_op), int'(b_op),
                              int'($signed(A)), int'($signed(B))));
    prev_stall = out_valid6 && !out_ready && !flush;
    prev_c6 = C6; prev_c5 = C5; prev_o6 = ovf6; prev_e6 = err6;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] mode, input int aop, input int bop,
                          input int a, input int b);
    {a_en, b_en} = mode;
    a_op = 3'(aop);
    b_op = 2'(bop);
    A = 5'(a);
    B = 5'(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 0; flush = 0; en = 1; in_valid = 0; out_ready = 1;
    set_beat(2'b00, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_in_ready", in_ready6, 1);
    chk("rst_out_valid", out_valid6, 0);
    chk("rst_c6", C6, 0);
    chk("rst_c5", C5, 0);
    chk("rst_txn", txn6, 0);
    @(posedge clk); #1;

    vecs[0]  = '{2'b10, 0, 0, -16, -16, 32, 0, 0, 16, 1, 0};
    vecs[1]  = '{2'b10, 0, 0, 15, 1, 16, 0, 16, 15, 1, 0};
    vecs[2]  = '{2'b11, 0, 2, -16, 0, 47, 0, 15, 16, 1, 0};
    vecs[3]  = '{2'b01, 0, 0, 0, 0, 63, 0, 31, 31, 0, 0};
    vecs[4]  = '{2'b00, 0, 0, 7, 3, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{2'b10, 1, 0, -16, 15, 33, 0, 1, 16, 1, 0};
    vecs[6]  = '{2'b10, 6, 0, 5, 3, 57, 0, 25, 25, 0, 0};
    vecs[7]  = '{2'b11, 0, 3, 0, 15, 17, 0, 17, 15, 1, 0};
    vecs[8]  = '{2'b10, 7, 0, 3, 4, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{2'b01, 0, 2, -16, -1, 47, 0, 15, 16, 1, 0};
    vecs[10] = '{2'b10, 4, 0, -1, 6, 6, 0, 6, 6, 0, 0};

    foreach (vecs[i]) begin
      set_beat(vecs[i].mode, vecs[i].aop, vecs[i].bop, vecs[i].a, vecs[i].b);
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid6, 1);
      chk($sformatf("vec%0d_c6", i), C6, vecs[i].c6);
      chk($sformatf("vec%0d_ovf6", i), ovf6, vecs[i].o6);
      chk($sformatf("vec%0d_err6", i), err6, vecs[i].e);
`ifdef ALU_SAT_EN
      chk($sformatf("vec%0d_c5", i), C5, vecs[i].c5s);
`else
      chk($sformatf("vec%0d_c5", i), C5, vecs[i].c5w);
`endif
      chk($sformatf("vec%0d_ovf5", i), ovf5, vecs[i].o5);
      tick();
    end

    en = 0; in_valid = 1; #1;
    chk("en_low_in_ready", in_ready6, 0);
    in_valid = 0; en = 1;
    tick();

    // Three back-to-back beats against a stalled consumer.
    base = exp_txn;
    out_ready = 0;
    in_valid = 1;
    set_beat(2'b11, 0, 2, -16, 0); tick();
    set_beat(2'b01, 0, 0, 0, 0);   tick();
    set_beat(2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bb_in_ready", in_ready6, 0);
      chk("bb_valid", out_valid6, 1);
      chk("bb_hold_c6", C6, 47);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bb_release_ready", in_ready6, 1);
    tick();
    in_valid = 0;
    repeat (4) tick();
    chk("bb_txn", txn6, base + 3);
    chk("bb_drained", sb_q.size(), 0);

    // Flush with both stages occupied.
    base = exp_txn;
    out_ready = 0;
    in_valid = 1;
    set_beat(2'b10, 0, 0, 1, 2); tick();
    set_beat(2'b10, 1, 0, 3, 1); tick();
    flush = 1; #1;
    chk("flush_in_ready", in_ready6, 0);
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid6, 0);
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_result", out_valid6, 0);
    end
    chk("flush_txn", txn6, base);

    // Asynchronous reset with S2 full and stalled.
    out_ready = 0;
    in_valid = 1;
    set_beat(2'b10, 0, 0, 5, 5); tick();
    in_valid = 0; tick();
    chk("pre_rst_valid", out_valid6, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid6, 0);
    chk("arst_c6", C6, 0);
    chk("arst_txn", txn6, 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_no_result", out_valid6, 0);
    end

    // Randomised traffic against the queue model.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      set_beat(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16);
      tick();
    end
    in_valid = 0; flush = 0; en = 1; out_ready = 1;
    repeat (4) tick();
    chk("rand_drained", sb_q.size(), 0);
    chk("rand_txn", txn6, exp_txn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
